// File: rtl/chua_stream_decryptor.sv
// Chua chaotic stream decryptor: loads three seeds from a frame header, then
// XORs each payload word with x[N:0] while stepping a fixed-point Chua
// iteration, one step per accepted payload word.
module chua_stream_decryptor #(
    parameter int unsigned N = 31
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       s_valid,
    output logic       s_ready,
    input  logic [N:0] s_data,
    input  logic       s_last,
    output logic       m_valid,
    input  logic       m_ready,
    output logic [N:0] m_data,
    output logic       m_last,
    output logic       locked,
    output logic       frame_done,
    output logic       frm_err
);

    localparam int unsigned XW = N + 4;
    localparam int unsigned YW = N + 2;

    typedef enum logic [1:0] {StHdrX, StHdrY, StHdrZ, StPayload} state_e;

    state_e        state_q, state_d;
    logic [XW-1:0] x_q, x_d, z_q, z_d;
    logic [YW-1:0] y_q, y_d;
    logic          m_valid_q, m_valid_d;
    logic [N:0]    m_data_q, m_data_d;
    logic          m_last_q, m_last_d;
    logic          frame_done_q, frame_done_d;
    logic          frm_err_q, frm_err_d;
    logic          accept;

    logic [XW-1:0] y_ext, diff, y_sum, m_val, a_val, b_val, x_next, z_next;
    logic [YW-1:0] y_next;
    logic          s_flag;

    // One Chua iteration from the current (pre-update) state.
    always_comb begin
        y_ext  = {2'b00, y_q};
        s_flag = (x_q[N+2:N] != 3'b000) && (x_q[N+2:N] != 3'b111);
        diff   = x_q + z_q - y_ext;
        y_sum  = (diff >> 4) + y_ext;
        y_next = y_sum[YW-1:0];
        z_next = z_q - y_ext;
        m_val  = s_flag ? (x_q >> 2) : (x_q >> 3);
        a_val  = m_val + (s_flag ? XW'(3) : '0);
        b_val  = s_flag ? (y_ext + a_val) : (y_ext - a_val);
        x_next = x_q + (b_val >> 1);
    end

    // Frame FSM next state, seed load, state advance and output slot.
    always_comb begin
        state_d      = state_q;
        x_d          = x_q;
        y_d          = y_q;
        z_d          = z_q;
        m_valid_d    = m_valid_q;
        m_data_d     = m_data_q;
        m_last_d     = m_last_q;
        frame_done_d = 1'b0;
        frm_err_d    = 1'b0;

        // Header words never touch the output slot, so a pending word may drain.
        s_ready = (state_q == StPayload) ? (!m_valid_q || m_ready) : 1'b1;
        accept  = s_valid && s_ready;

        if (m_valid_q && m_ready) begin
            m_valid_d = 1'b0;
        end

        if (accept) begin
            unique case (state_q)
                StHdrX: begin
                    x_d     = {3'b000, s_data};
                    state_d = StHdrY;
                end
                StHdrY: begin
                    y_d     = {1'b0, s_data};
                    state_d = StHdrZ;
                end
                StHdrZ: begin
                    z_d     = {3'b000, s_data};
                    state_d = StPayload;
                end
                StPayload: begin
                    m_valid_d = 1'b1;
                    m_data_d  = s_data ^ x_q[N:0];
                    m_last_d  = s_last;
                    x_d       = x_next;
                    y_d       = y_next;
                    z_d       = z_next;
                    if (s_last) begin
                        state_d      = StHdrX;
                        frame_done_d = 1'b1;
                    end
                end
                default: state_d = StHdrX;
            endcase

            // A truncated header aborts the frame and drops any partial seeds.
            if (s_last && (state_q != StPayload)) begin
                state_d   = StHdrX;
                frm_err_d = 1'b1;
                x_d       = '0;
                y_d       = '0;
                z_d       = '0;
            end
        end
    end

    // State, chaotic registers and output slot with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StHdrX;
            x_q          <= '0;
            y_q          <= '0;
            z_q          <= '0;
            m_valid_q    <= 1'b0;
            m_data_q     <= '0;
            m_last_q     <= 1'b0;
            frame_done_q <= 1'b0;
            frm_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            x_q          <= x_d;
            y_q          <= y_d;
            z_q          <= z_d;
            m_valid_q    <= m_valid_d;
            m_data_q     <= m_data_d;
            m_last_q     <= m_last_d;
            frame_done_q <= frame_done_d;
            frm_err_q    <= frm_err_d;
        end
    end

    assign m_valid    = m_valid_q;
    assign m_data     = m_data_q;
    assign m_last     = m_last_q;
    assign frame_done = frame_done_q;
    assign frm_err    = frm_err_q;
    assign locked     = (state_q == StPayload);

endmodule

// File: tb/tb_chua_stream_decryptor.sv
// Directed and golden-model bench for chua_stream_decryptor.
module tb_chua_stream_decryptor;

    localparam int NW = 10000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        s_valid = 1'b0;
    logic        s_ready;
    logic [31:0] s_data = '0;
    logic        s_last = 1'b0;
    logic        m_valid;
    logic        m_ready = 1'b1;
    logic [31:0] m_data;
    logic        m_last;
    logic        locked;
    logic        frame_done;
    logic        frm_err;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] got[$];
    logic [31:0] pt[NW];
    logic [31:0] exp_ct[NW];

    always #5 clk = ~clk;

    chua_stream_decryptor #(.N(31)) dut (
        .clk       (clk),
        .rst       (rst),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .s_data    (s_data),
        .s_last    (s_last),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .m_data    (m_data),
        .m_last    (m_last),
        .locked    (locked),
        .frame_done(frame_done),
        .frm_err   (frm_err)
    );

    // Records every output word that the downstream handshake takes.
    always @(negedge clk) begin
        if (!rst && m_valid && m_ready) got.push_back(m_data);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one word and return one step after the edge that accepts it.
    task automatic send(input logic [31:0] d, input logic l);
        int waited = 0;
        s_valid = 1'b1;
        s_data  = d;
        s_last  = l;
        #1;
        while (!s_ready && waited < 50) begin
            tick();
            waited++;
        end
        if (waited >= 50) begin
            n_checks++;
            n_fail++;
            $display("FAIL send_timeout s_ready=%b required=1", s_ready);
        end
        tick();
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic send_seeds(input logic [31:0] sx, input logic [31:0] sy,
                              input logic [31:0] sz);
        send(sx, 1'b0);
        send(sy, 1'b0);
        send(sz, 1'b0);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        n_checks++; if (m_valid !== 1'b0) begin n_fail++; $display("FAIL rst_m_valid got=%b exp=0", m_valid); end
        n_checks++; if (m_data !== 32'h0) begin n_fail++; $display("FAIL rst_m_data got=%h exp=0", m_data); end
        n_checks++; if (m_last !== 1'b0) begin n_fail++; $display("FAIL rst_m_last got=%b exp=0", m_last); end
        n_checks++; if (locked !== 1'b0) begin n_fail++; $display("FAIL rst_locked got=%b exp=0", locked); end
        n_checks++; if (frame_done !== 1'b0 || frm_err !== 1'b0) begin n_fail++; $display("FAIL rst_pulses got=%b%b exp=00", frame_done, frm_err); end
        n_checks++; if (s_ready !== 1'b1) begin n_fail++; $display("FAIL rst_s_ready got=%b exp=1", s_ready); end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_basic();
        got.delete();
        m_ready = 1'b1;
        send_seeds(32'h3FF9999A, 32'h3FF9999A, 32'h3F147AE1);
        n_checks++; if (locked !== 1'b1) begin n_fail++; $display("FAIL basic_locked got=%b exp=1", locked); end
        send(32'h0, 1'b0);
        n_checks++; if (m_valid !== 1'b1 || m_data !== 32'h3FF9999A) begin n_fail++; $display("FAIL basic_w0 got=%b/%h exp=1/3ff9999a", m_valid, m_data); end
        n_checks++; if (m_last !== 1'b0) begin n_fail++; $display("FAIL basic_w0_last got=%b exp=0", m_last); end
        send(32'h0, 1'b1);
        n_checks++; if (m_data !== 32'h5BF6CCCD) begin n_fail++; $display("FAIL basic_w1 got=%h exp=5bf6cccd", m_data); end
        n_checks++; if (m_last !== 1'b1) begin n_fail++; $display("FAIL basic_w1_last got=%b exp=1", m_last); end
        n_checks++; if (frame_done !== 1'b1) begin n_fail++; $display("FAIL basic_done got=%b exp=1", frame_done); end
        n_checks++; if (locked !== 1'b0) begin n_fail++; $display("FAIL basic_unlock got=%b exp=0", locked); end
        tick();
        n_checks++; if (frame_done !== 1'b0) begin n_fail++; $display("FAIL basic_done_pulse got=%b exp=0", frame_done); end
        n_checks++; if (m_valid !== 1'b0) begin n_fail++; $display("FAIL basic_drained got=%b exp=0", m_valid); end
        n_checks++; if (got.size() != 2) begin n_fail++; $display("FAIL basic_count got=%0d exp=2", got.size()); end
    endtask

    task automatic test_backpressure();
        got.delete();
        m_ready = 1'b1;
        send_seeds(32'h3FF9999A, 32'h3FF9999A, 32'h3F147AE1);
        send(32'h0, 1'b0);
        m_ready = 1'b0;
        s_valid = 1'b1;
        s_data  = 32'h0;
        s_last  = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            n_checks++;
            if (m_valid !== 1'b1 || m_data !== 32'h3FF9999A || s_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL bp_hold cyc=%0d got v=%b d=%h rdy=%b exp v=1 d=3ff9999a rdy=0",
                         i, m_valid, m_data, s_ready);
            end
        end
        m_ready = 1'b1;
        tick();
        s_valid = 1'b0;
        s_last  = 1'b0;
        n_checks++; if (m_data !== 32'h5BF6CCCD || m_last !== 1'b1) begin n_fail++; $display("FAIL bp_w1 got=%h/%b exp=5bf6cccd/1", m_data, m_last); end
        n_checks++; if (frame_done !== 1'b1) begin n_fail++; $display("FAIL bp_done got=%b exp=1", frame_done); end
        tick();
        n_checks++;
        if (got.size() != 2) begin
            n_fail++;
            $display("FAIL bp_count got=%0d exp=2", got.size());
        end else if (got[0] !== 32'h3FF9999A || got[1] !== 32'h5BF6CCCD) begin
            n_fail++;
            $display("FAIL bp_order got=%h,%h exp=3ff9999a,5bf6cccd", got[0], got[1]);
        end
    endtask

    task automatic test_hdr_abort();
        m_ready = 1'b1;
        send(32'h3FF9999A, 1'b0);
        send(32'h3FF9999A, 1'b1);
        n_checks++; if (frm_err !== 1'b1) begin n_fail++; $display("FAIL abort_err got=%b exp=1", frm_err); end
        n_checks++; if (locked !== 1'b0) begin n_fail++; $display("FAIL abort_locked got=%b exp=0", locked); end
        tick();
        n_checks++; if (frm_err !== 1'b0) begin n_fail++; $display("FAIL abort_err_pulse got=%b exp=0", frm_err); end
        send_seeds(32'h3FF9999A, 32'h3FF9999A, 32'h3F147AE1);
        send(32'h0, 1'b0);
        n_checks++; if (m_data !== 32'h3FF9999A) begin n_fail++; $display("FAIL abort_w0 got=%h exp=3ff9999a", m_data); end
        send(32'h0, 1'b1);
        n_checks++; if (m_data !== 32'h5BF6CCCD) begin n_fail++; $display("FAIL abort_w1 got=%h exp=5bf6cccd", m_data); end
        tick();
    endtask

    task automatic test_back_to_back();
        m_ready = 1'b1;
        for (int f = 0; f < 2; f++) begin
            send_seeds(32'h3FF9999A, 32'h3FF9999A, 32'h3F147AE1);
            send(32'hFFFFFFFF, 1'b1);
            n_checks++;
            if (m_data !== 32'hC0066665 || m_last !== 1'b1) begin
                n_fail++;
                $display("FAIL b2b_frame%0d got=%h/%b exp=c0066665/1", f, m_data, m_last);
            end
        end
        tick();
    endtask

    task automatic test_reset_mid();
        m_ready = 1'b1;
        send_seeds(32'h3FF9999A, 32'h3FF9999A, 32'h3F147AE1);
        m_ready = 1'b0;
        send(32'h0, 1'b0);
        n_checks++; if (m_valid !== 1'b1 || locked !== 1'b1) begin n_fail++; $display("FAIL rmid_pre got=%b%b exp=11", m_valid, locked); end
        rst = 1'b1;
        tick();
        n_checks++; if (m_valid !== 1'b0) begin n_fail++; $display("FAIL rmid_valid got=%b exp=0", m_valid); end
        n_checks++; if (locked !== 1'b0) begin n_fail++; $display("FAIL rmid_locked got=%b exp=0", locked); end
        n_checks++; if (m_data !== 32'h0) begin n_fail++; $display("FAIL rmid_data got=%h exp=0", m_data); end
        rst = 1'b0;
        m_ready = 1'b1;
        tick();
        send_seeds(32'h3FF9999A, 32'h3FF9999A, 32'h3F147AE1);
        send(32'h0, 1'b0);
        n_checks++; if (m_data !== 32'h3FF9999A) begin n_fail++; $display("FAIL rmid_w0 got=%h exp=3ff9999a", m_data); end
        send(32'h0, 1'b1);
        n_checks++; if (m_data !== 32'h5BF6CCCD) begin n_fail++; $display("FAIL rmid_w1 got=%h exp=5bf6cccd", m_data); end
        tick();
    endtask

    // 10k random payload words under random backpressure against a software model.
    task automatic test_random();
        longint unsigned mk35 = (64'd1 << 35) - 1;
        longint unsigned mk33 = (64'd1 << 33) - 1;
        longint unsigned x, y, z, xn, yn, zn, m, a, b, top;
        logic [31:0] sx, sy, sz;
        bit s;
        int i = 0;
        int budget = 0;
        logic acc;
        sx = $urandom();
        sy = $urandom();
        sz = $urandom();
        x = 64'(sx);
        y = 64'(sy);
        z = 64'(sz);
        for (int k = 0; k < NW; k++) begin
            pt[k]     = $urandom();
            exp_ct[k] = pt[k] ^ x[31:0];
            top = (x >> 31) & 64'd7;
            s   = (top != 64'd0) && (top != 64'd7);
            yn  = ((((x + z - y) & mk35) >> 4) + y) & mk33;
            zn  = (z - y) & mk35;
            m   = s ? (x >> 2) : (x >> 3);
            a   = m + (s ? 64'd3 : 64'd0);
            b   = (s ? (y + a) : (y - a)) & mk35;
            xn  = (x + (b >> 1)) & mk35;
            x = xn;
            y = yn;
            z = zn;
        end
        m_ready = 1'b1;
        send_seeds(sx, sy, sz);
        got.delete();
        while (i < NW && budget < 60000) begin
            m_ready = ($urandom_range(0, 3) != 0);
            s_valid = 1'b1;
            s_data  = pt[i];
            s_last  = (i == NW - 1);
            #1;
            acc = s_ready;
            tick();
            if (acc) i++;
            budget++;
        end
        s_valid = 1'b0;
        s_last  = 1'b0;
        m_ready = 1'b1;
        for (int w = 0; w < 20 && got.size() < NW; w++) tick();
        n_checks++;
        if (got.size() != NW) begin
            n_fail++;
            $display("FAIL rand_count got=%0d exp=%0d", got.size(), NW);
        end
        for (int k = 0; k < NW && k < got.size(); k++) begin
            n_checks++;
            if (got[k] !== exp_ct[k]) begin
                n_fail++;
                $display("FAIL rand_word idx=%0d got=%h exp=%h", k, got[k], exp_ct[k]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_hdr_abort();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
